// File: rtl/network_tx_queue.sv
// network_tx_queue: elastic TX FIFO between the RPC serialization stage and
// the network port. Pushes are valid-only strobes without backpressure. Drains
// use a valid/ready handshake. The block reports occupancy and almost-full,
// and keeps a saturating count of packets dropped on overflow.

package network_tx_pkg;

  typedef struct packed {
    logic [15:0] conn_id;
    logic [15:0] payload_size;
  } net_hdr_t;

  typedef struct packed {
    net_hdr_t    hdr;
    logic [63:0] payload;
  } NetworkPacketInternal;

endpackage

module network_tx_queue
  import network_tx_pkg::*;
#(
  parameter logic [31:0] NIC_ID    = 32'h0,
  parameter int          DEPTH     = 16,
  parameter int          AFULL_THR = 12
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  NetworkPacketInternal         network_tx_in,
  input  logic                         network_tx_valid_in,
  input  logic                         flush_in,
  output NetworkPacketInternal         network_tx_out,
  output logic                         network_tx_valid_out,
  input  logic                         network_tx_ready_in,
  output logic [$clog2(DEPTH+1)-1:0]   count_out,
  output logic                         almost_full_out,
  output logic [31:0]                  drop_cnt_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THR);

  // An illegal configuration elaborates this block; the instance id is kept
  // here so that it is visible in the elaborated hierarchy for debug.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (AFULL_THR < 1) || (AFULL_THR > DEPTH)) begin : g_invalid_cfg
    logic [31:0] bad_cfg_nic_id_s;
    assign bad_cfg_nic_id_s = NIC_ID;
  end

  // Reset synchronizer: assertion passes straight through, release is
  // aligned to clk after two edges.
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_n_s;

  NetworkPacketInternal mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          afull_q, afull_d;
  logic [31:0]   drop_cnt_q, drop_cnt_d;

  logic full_s;
  logic pop_s;
  logic push_s;
  logic drop_s;
  logic mem_we_s;

  // Shift a one into the synchronizer each cycle once reset_n is high.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset synchronizer flops, cleared asynchronously by reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n_s = rst_sync_q[1];

  // Handshake decode, pointer/count next state, drop accounting and flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    mem_we_s   = 1'b0;

    full_s = (count_q == DEPTH_C);
    pop_s  = valid_q && network_tx_ready_in;
    push_s = network_tx_valid_in && (!full_s || pop_s);
    drop_s = network_tx_valid_in && full_s && !pop_s;

    if (flush_in) begin
      // Flush wins: concurrent push is discarded silently, drops are kept.
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_we_s = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase

      if (drop_s && (drop_cnt_q != 32'hFFFF_FFFF)) begin
        drop_cnt_d = drop_cnt_q + 32'd1;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end

    // Flags follow next-state count so they line up with count_out.
    valid_d = (count_d != {CW{1'b0}});
    afull_d = (count_d >= AFULL_C);
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      valid_q    <= 1'b0;
      afull_q    <= 1'b0;
      drop_cnt_q <= 32'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      afull_q    <= afull_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Packet storage; intentionally not reset, contents are qualified by valid.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= network_tx_in;
    end
  end

  assign network_tx_out       = mem_q[rd_ptr_q];
  assign network_tx_valid_out = valid_q;
  assign count_out            = count_q;
  assign almost_full_out      = afull_q;
  assign drop_cnt_out         = drop_cnt_q;

endmodule
